sq_period_meter: RTL and testbench
==================================

// Module: sq_period_meter
// PURPOSE
//  Downstream consumer of the square-wave generator's clk_out. Measures the high and low
//  widths of each full period of sq_in, in clk cycles. Presents each completed period
//  as a result word with a valid/ack handshake. Lets firmware or the bench confirm that
//  the programmed rise/fall widths actually appear on the wire.
// PARAMETERS
//  CNT_W   8   width of each width counter and result field; saturates at 2**CNT_W-1
// PORTS
//  clk        in   1      system clock, same clock that drives the generator
//  rst        in   1      synchronous, active-high reset
//  sq_in      in   1      square wave under measurement (generator clk_out)
//  high_cnt   out  CNT_W  high width of last completed period, in clk cycles
//  low_cnt    out  CNT_W  low width of last completed period, in clk cycles
//  overflow   out  1      high_cnt or low_cnt saturated in the reported period
//  meas_valid out  1      result registers hold an unacknowledged measurement
//  meas_ack   in   1      consumer accepts the result; only effective while meas_valid=1
//  meas_drop  out  1      1-cycle pulse: unacknowledged result overwritten by a new one
// BEHAVIOUR
//  - Reset: high_cnt=0, low_cnt=0, overflow=0, meas_valid=0, meas_drop=0,
//    FSM=WAIT_RISE, accumulators=0, prev-sample reg sq_d=1.
//  - sq_d=1 at reset means sq_in held high through reset is not treated as a rising edge.
//    A true 0->1 transition is required.
//  - Edge detect uses the sampled input s (sq_in, or the synchronised copy):
//    rise = s & ~sq_d; fall = ~s & sq_d.
//  - FSM states:
//    WAIT_RISE: ignore input until rise; on rise: hi_acc<=1, ovf<=0 -> MEAS_HIGH.
//    MEAS_HIGH: s=1: hi_acc+=1 (saturating; ovf<=1 on saturation).
//               fall: lo_acc<=1 -> MEAS_LOW.
//    MEAS_LOW:  s=0: lo_acc+=1 (saturating; ovf<=1 on saturation).
//               rise: capture, then hi_acc<=1, ovf<=0 -> MEAS_HIGH.
//  - Capture (on rise in MEAS_LOW): high_cnt<=hi_acc, low_cnt<=lo_acc, overflow<=ovf,
//    meas_valid<=1.
//    * Results are registered and appear the cycle after the rising-edge sample.
//    * Measurement is back-to-back: the rise that closes one period opens the next.
//  - Counts are exact: hi_acc = number of cycles s was sampled 1; lo_acc = number of
//    cycles s was sampled 0. Minimum reportable width is 1.
//  - Handshake:
//    * meas_valid & meas_ack with no capture that cycle -> meas_valid<=0.
//    * Capture while meas_valid=1 and no ack -> new data overwrites, meas_valid stays 1,
//      meas_drop=1 for one cycle.
//    * Capture with ack in the same cycle -> new data loads, meas_valid stays 1,
//      no drop.
//    * meas_ack while meas_valid=0 is ignored.
//  - Saturation: an accumulator holds at 2**CNT_W-1 and does not wrap. The FSM still
//    tracks edges, so a stuck input reports nothing until the next edge.
//  - Reset mid-operation: partial period discarded, all outputs return to reset values,
//    FSM returns to WAIT_RISE.
// CONFIGURATION
//  SQ_PERIOD_METER_SYNC_EN defined: sq_in passes through a 2-flop synchroniser (reset 1)
//    before edge detect. All latencies grow by 2 cycles; widths are unchanged.
//  Undefined: sq_in is sampled directly and must be synchronous to clk.
// TESTING
//  1 sq_in 3 high/4 low repeating, meas_ack tied 1 -> meas_valid once per 7 cycles,
//    high_cnt=3, low_cnt=4, overflow=0, meas_drop never.
//  2 Change stream to 5 high/4 low at a period boundary -> next report 5/4,
//    no mixed 3/4 values after that.
//  3 CNT_W=4, sq_in 20 high/2 low -> high_cnt=15, low_cnt=2, overflow=1.
//    Following 3/4 period -> overflow=0.
//  4 meas_ack held 0 for two periods of 3/4 -> meas_valid stays 1, meas_drop pulses
//    once, data=3/4. Then ack -> meas_valid=0 next cycle.
//  5 rst pulsed mid-high with sq_in held 1 -> all outputs 0, no report until a 0->1
//    transition plus one full period.
//  6 Run 1 with SQ_PERIOD_METER_SYNC_EN -> identical counts, first meas_valid 2 cycles
//    later than without the macro.

Source files
------------

// File: rtl/sq_period_meter.sv
// Square-wave period meter: reports the high/low widths (in clk cycles) of each full sq_in period.
// Define SQ_PERIOD_METER_SYNC_EN to put sq_in through a 2-flop synchroniser before edge detect.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// WAIT_RISE | idle after reset, waiting for the first true 0->1 transition
// MEAS_HIGH | counting cycles sampled high in the current period
// MEAS_LOW  | counting cycles sampled low; the next rise closes the period

module sq_period_meter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sq_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic             overflow,
  output logic             meas_valid,
  input  logic             meas_ack,
  output logic             meas_drop
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    WAIT_RISE,
    MEAS_HIGH,
    MEAS_LOW
  } state_t;

  state_t           state;
  logic             s;
  logic             sq_d;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] hi_acc;
  logic [CNT_W-1:0] lo_acc;
  logic             ovf;

`ifdef SQ_PERIOD_METER_SYNC_EN
  // Synchroniser resets high so a line held high through reset is not seen as a rise.
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], sq_in};
    end
  end

  assign s = sync_q[1];
`else
  assign s = sq_in;
`endif

  assign rise = s & ~sq_d;
  assign fall = ~s & sq_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_RISE;
      sq_d       <= 1'b1;
      hi_acc     <= '0;
      lo_acc     <= '0;
      ovf        <= 1'b0;
      high_cnt   <= '0;
      low_cnt    <= '0;
      overflow   <= 1'b0;
      meas_valid <= 1'b0;
      meas_drop  <= 1'b0;
    end else begin
      sq_d      <= s;
      meas_drop <= 1'b0;

      // A capture below overrides this clear when both happen in one cycle.
      if (meas_valid && meas_ack) begin
        meas_valid <= 1'b0;
      end

      case (state)
        WAIT_RISE: begin
          if (rise) begin
            hi_acc <= CNT_ONE;
            ovf    <= 1'b0;
            state  <= MEAS_HIGH;
          end
        end

        MEAS_HIGH: begin
          if (fall) begin
            lo_acc <= CNT_ONE;
            state  <= MEAS_LOW;
          end else if (s) begin
            if (hi_acc == CNT_MAX) begin
              ovf <= 1'b1;
            end else begin
              hi_acc <= hi_acc + CNT_ONE;
            end
          end
        end

        MEAS_LOW: begin
          if (rise) begin
            high_cnt   <= hi_acc;
            low_cnt    <= lo_acc;
            overflow   <= ovf;
            meas_valid <= 1'b1;
            meas_drop  <= meas_valid & ~meas_ack;
            hi_acc     <= CNT_ONE;
            ovf        <= 1'b0;
            state      <= MEAS_HIGH;
          end else if (!s) begin
            if (lo_acc == CNT_MAX) begin
              ovf <= 1'b1;
            end else begin
              lo_acc <= lo_acc + CNT_ONE;
            end
          end
        end

        default: begin
          state <= WAIT_RISE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sq_period_meter.sv
// Scoreboard bench for sq_period_meter: stimulus pushes expected widths, the monitor pops on each accepted result.
// Builds with or without SQ_PERIOD_METER_SYNC_EN; only the expected latency offset changes.

module tb_sq_period_meter;

  localparam int CNT_W = 8;
`ifdef SQ_PERIOD_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sq_in = 1'b0;
  logic             meas_ack = 1'b1;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic             overflow;
  logic             meas_valid;
  logic             meas_drop;

  sq_period_meter #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .sq_in      (sq_in),
    .high_cnt   (high_cnt),
    .low_cnt    (low_cnt),
    .overflow   (overflow),
    .meas_valid (meas_valid),
    .meas_ack   (meas_ack),
    .meas_drop  (meas_drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CNT_W-1:0] hi;
    logic [CNT_W-1:0] lo;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   drop_seen = 0;
  int   first_valid_cyc = -1;
  int   n0;
  int   d0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int hi, input int lo, input bit ovf);
    exp_t e;
    e.hi  = CNT_W'(hi);
    e.lo  = CNT_W'(lo);
    e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  task automatic drive_bit(input logic v);
    sq_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_period(input int h, input int l);
    repeat (h) drive_bit(1'b1);
    repeat (l) drive_bit(1'b0);
  endtask

  // Monitor: every accepted result (valid & ack) must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (meas_drop) drop_seen++;
      if (meas_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (meas_valid && meas_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_report: got hi=%0d lo=%0d ovf=%0d, expected no report (cycle %0d)",
                   high_cnt, low_cnt, overflow, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("high_cnt", 32'(high_cnt), 32'(e.hi));
          chk("low_cnt", 32'(low_cnt), 32'(e.lo));
          chk("overflow", 32'(overflow), 32'(e.ovf));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_high_cnt", 32'(high_cnt), 0);
    chk("rst_low_cnt", 32'(low_cnt), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_meas_valid", 32'(meas_valid), 0);
    chk("rst_meas_drop", 32'(meas_drop), 0);
    rst = 1'b0;
    drive_bit(1'b0);
    drive_bit(1'b0);

    // 1: 3 high / 4 low, ack tied high
    n0 = cyc;
    for (int i = 0; i < 4; i++) begin
      push(3, 4, 1'b0);
      drive_period(3, 4);
    end

    // 2: switch to 5 high / 4 low at a period boundary
    for (int i = 0; i < 3; i++) begin
      push(5, 4, 1'b0);
      drive_period(5, 4);
    end
    chk("no_drop_streaming", 32'(drop_seen), 0);

    // 3: saturated high phase, then a normal period clears overflow
    push(255, 2, 1'b1);
    drive_period(300, 2);
    push(3, 4, 1'b0);
    drive_period(3, 4);
    chk("no_drop_saturation", 32'(drop_seen), 0);

    // 4: ack withheld across two periods; A is overwritten by B
    for (int i = 0; i < 7; i++) begin
      if (i == 2 + LAT) meas_ack = 1'b0;
      drive_bit(i < 3);
    end
    push(3, 4, 1'b0);
    drive_period(3, 4);
    chk("valid_held", 32'(meas_valid), 1);
    d0 = drop_seen;
    for (int i = 0; i <= LAT; i++) drive_bit(1'b1);
    chk("drop_pulse", 32'(meas_drop), 1);
    chk("valid_after_drop", 32'(meas_valid), 1);
    meas_ack = 1'b1;
    drive_bit(1'b1);
    meas_ack = 1'b0;
    chk("valid_cleared_by_ack", 32'(meas_valid), 0);
    chk("drop_once", 32'(drop_seen - d0), 1);
    chk("drop_single_cycle", 32'(meas_drop), 0);
    repeat (4) drive_bit(1'b0);

    // 5: reset mid-high with sq_in held high
    for (int i = 0; i < 2 + LAT; i++) drive_bit(1'b1);
    rst = 1'b1;
    drive_bit(1'b1);
    drive_bit(1'b1);
    chk("mid_rst_high_cnt", 32'(high_cnt), 0);
    chk("mid_rst_low_cnt", 32'(low_cnt), 0);
    chk("mid_rst_overflow", 32'(overflow), 0);
    chk("mid_rst_meas_valid", 32'(meas_valid), 0);
    chk("mid_rst_meas_drop", 32'(meas_drop), 0);
    rst = 1'b0;
    meas_ack = 1'b1;
    repeat (4) drive_bit(1'b1);
    repeat (3) drive_bit(1'b0);
    chk("no_report_held_high", 32'(meas_valid), 0);
    drive_period(3, 4);
    push(3, 4, 1'b0);
    for (int i = 0; i < LAT + 3; i++) drive_bit(1'b1);

    // 1/6: first report latency from first sampled rise
    chk("first_valid_latency", 32'(first_valid_cyc - n0), 32'(8 + LAT));
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
